// File: rtl/multadd_result_rx.sv
// Receive side of the fixed-latency multiply-add core: tracks issued operands,
// captures P after LATENCY cycles, rounds/saturates and streams results out of a credit-protected FIFO.
module multadd_result_rx #(
  parameter int LATENCY    = 4,
  parameter int P_WIDTH    = 64,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAC_SHIFT = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [P_WIDTH-1:0]   P,
  output logic signed [OUT_WIDTH-1:0] m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [15:0]                 sat_cnt,
  output logic                        proto_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic signed [P_WIDTH:0] wide_t;
  localparam wide_t ONE_W = wide_t'(1);
  localparam wide_t HALF  = ONE_W <<< (FRAC_SHIFT - 1);
  localparam wide_t RMAX  = (ONE_W <<< (OUT_WIDTH - 1)) - ONE_W;
  localparam wide_t RMIN  = -(ONE_W <<< (OUT_WIDTH - 1));

  // Extra headroom bit keeps the rounding add from wrapping near full scale.
  function automatic wide_t round_shift(input logic signed [P_WIDTH-1:0] p);
    wide_t sum;
    sum = wide_t'(p) + HALF;
    return sum >>> FRAC_SHIFT;
  endfunction

  function automatic logic is_sat(input wide_t r);
    return (r > RMAX) || (r < RMIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input wide_t r);
    if (r > RMAX)      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (r < RMIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else               return r[OUT_WIDTH-1:0];
  endfunction

  logic [1:0]                  r_rst_sync;
  logic                        w_rst_n;
  logic [LATENCY-1:0]          r_vld_sr;
  logic [CW-1:0]               r_inflight;
  logic [CW-1:0]               r_count;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic signed [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic signed [OUT_WIDTH-1:0] r_res_p0;
  logic                        r_sat_p0;
  logic                        r_vld_p0;
  logic [15:0]                 r_sat_cnt;
  logic                        r_proto_err;
  logic                        w_issue;
  logic                        w_cap;
  logic                        w_wr;
  logic                        w_pop;
  logic [CW:0]                 w_credit;
  wide_t                       w_r;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_credit = {1'b0, r_count} + {1'b0, r_inflight};
  assign in_ready = w_credit < (CW+1)'(FIFO_DEPTH);
  assign w_issue  = in_valid & in_ready;
  assign w_cap    = r_vld_sr[LATENCY-1];
  assign w_wr     = r_vld_p0;
  assign m_tvalid = (r_count != '0);
  assign w_pop    = m_tvalid & m_tready;
  assign w_r      = round_shift(P);

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld_sr    <= '0;
      r_vld_p0    <= 1'b0;
      r_inflight  <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sat_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_vld_sr   <= LATENCY'({r_vld_sr, w_issue});
      r_vld_p0   <= w_cap;
      // Inflight covers the shift register plus the rounding stage, so it drops on the write.
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_wr);
      r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && r_sat_p0 && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
      if (in_valid && !in_ready) r_proto_err <= 1'b1;
    end
  end

  // Stage p0: round, shift and saturate the captured P
  always_ff @(posedge CLK) begin
    if (w_cap) begin
      r_res_p0 <= saturate(w_r);
      r_sat_p0 <= is_sat(w_r);
    end
  end

  // FIFO write one cycle after capture
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_res_p0;
  end

  assign m_tdata   = m_tvalid ? r_mem[r_rd_ptr] : '0;
  assign sat_cnt   = r_sat_cnt;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_multadd_result_rx.sv
// Directed bench for multadd_result_rx: rounding, saturation, backpressure, protocol error and reset.
module tb_multadd_result_rx;
  localparam int LATENCY    = 4;
  localparam int P_WIDTH    = 64;
  localparam int OUT_WIDTH  = 32;
  localparam int FIFO_DEPTH = 8;

  logic                 CLK = 1'b0;
  logic                 RESETN = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 m_tready = 1'b0;
  logic                 in_ready;
  logic [P_WIDTH-1:0]   P;
  logic [OUT_WIDTH-1:0] m_tdata;
  logic                 m_tvalid;
  logic [15:0]          sat_cnt;
  logic                 proto_err;
  logic [P_WIDTH-1:0]   p_next = '0;
  logic [P_WIDTH-1:0]   p_pipe [LATENCY];

  multadd_result_rx #(
    .LATENCY(LATENCY), .P_WIDTH(P_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .FRAC_SHIFT(16), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .sat_cnt(sat_cnt), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  // Behavioural multiply-add: result appears on P exactly LATENCY cycles after the operands
  always @(posedge CLK) begin
    for (int i = LATENCY-1; i > 0; i--) p_pipe[i] <= p_pipe[i-1];
    p_pipe[0] <= p_next;
  end
  assign P = p_pipe[LATENCY-1];

  typedef struct {
    logic [63:0] p;
    logic [31:0] exp;
  } vec_t;

  vec_t        tv [9];
  logic [31:0] got [$];
  int          got_cyc [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          first_vld = -1;
  int          issue_cyc;
  int          acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample outputs on the falling edge, then advance to just after the next rising edge
  task automatic tick();
    @(negedge CLK);
    if (m_tvalid && m_tready) begin
      got.push_back(m_tdata);
      got_cyc.push_back(cyc);
    end
    if (m_tvalid && first_vld < 0) first_vld = cyc;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int k = 1; k <= 4; k++) begin
      logic [63:0] a, b, c;
      a = 64'(k) * 64'h10000;
      b = 64'h10000;
      c = 64'(k) * 64'h20000;
      tv[k-1].p = a * b + c;
    end
    tv[0].exp = 32'h00010002;
    tv[1].exp = 32'h00020004;
    tv[2].exp = 32'h00030006;
    tv[3].exp = 32'h00040008;
    tv[4] = '{64'h0000_0000_0000_8000, 32'h00000001};
    tv[5] = '{64'h0000_0000_0000_7FFF, 32'h00000000};
    tv[6] = '{64'hFFFF_FFFF_FFFF_8000, 32'h00000000};
    tv[7] = '{64'h0000_8000_0000_0000, 32'h7FFFFFFF};
    tv[8] = '{64'hFFFF_0000_0000_0000, 32'h80000000};

    // Reset state
    #100;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    #70;
    RESETN = 1'b1;
    #1;
    chk("ready_after_release", 64'(in_ready), 64'd1);
    repeat (3) tick();

    // Ordering, rounding and saturation, back-to-back issue
    m_tready = 1'b1;
    got.delete();
    got_cyc.delete();
    first_vld = -1;
    issue_cyc = cyc;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      p_next   = tv[i].p;
      tick();
    end
    in_valid = 1'b0;
    p_next   = '0;
    wait_got(9, 40);
    chk("vec_count", 64'(got.size()), 64'd9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk($sformatf("vec%0d_tdata", i), 64'(got[i]), 64'(tv[i].exp));
    chk("first_valid_latency", 64'(first_vld - issue_cyc), 64'd6);
    if (got_cyc.size() == 9)
      chk("throughput_span", 64'(got_cyc[8] - got_cyc[0]), 64'd8);
    chk("sat_cnt_two", 64'(sat_cnt), 64'd2);
    chk("no_proto_err", 64'(proto_err), 64'd0);

    // Backpressure: issue whenever ready, with the sink stalled
    m_tready = 1'b0;
    got.delete();
    tick();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        in_valid = 1'b1;
        p_next   = 64'(100 + acc) << 16;
        acc++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd8);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    chk("bp_tvalid", 64'(m_tvalid), 64'd1);
    chk("bp_head", 64'(m_tdata), 64'd100);

    // Illegal issue while full
    in_valid = 1'b1;
    p_next   = 64'h7777 << 16;
    tick();
    in_valid = 1'b0;
    p_next   = '0;
    chk("proto_err_set", 64'(proto_err), 64'd1);
    repeat (8) tick();
    chk("bp_head_stable", 64'(m_tdata), 64'd100);
    chk("bp_ready_still_low", 64'(in_ready), 64'd0);

    // Drain: credit returns the cycle after the first pop
    m_tready = 1'b1;
    chk("ready_before_pop", 64'(in_ready), 64'd0);
    tick();
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    wait_got(8, 30);
    repeat (10) tick();
    chk("drain_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("drain%0d", i), 64'(got[i]), 64'(100 + i));
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // Reset with 5 buffered and 3 in flight
    m_tready = 1'b0;
    got.delete();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      p_next   = 64'h7FFF_0000_0000_0000;
      tick();
    end
    in_valid = 1'b0;
    repeat (LATENCY + 3) tick();
    chk("pre_rst_sat_cnt", 64'(sat_cnt), 64'd7);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      p_next   = 64'h8000_0000_0000_0000;
      tick();
    end
    in_valid = 1'b0;
    p_next   = '0;
    #2;
    RESETN = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("midrst_proto_err", 64'(proto_err), 64'd0);
    #20;
    RESETN = 1'b1;
    m_tready = 1'b1;
    got.delete();
    repeat (30) tick();
    chk("no_stale_samples", 64'(got.size()), 64'd0);
    chk("post_rst_sat_cnt", 64'(sat_cnt), 64'd0);

    // Recovery after reset
    in_valid = 1'b1;
    p_next   = 64'h0000_0000_0005_0000;
    tick();
    in_valid = 1'b0;
    p_next   = '0;
    wait_got(1, 20);
    chk("recover_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("recover_tdata", 64'(got[0]), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
